vram_mc: RTL and testbench

//  Multi-channel VDP video RAM: single-port inferred sync RAM shared by one CPU port (TMS9918 style

---
 rtl/vram_mc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vram_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_mc.sv
// vram_mc: multi-channel VDP video RAM.
//
// One single-port synchronous RAM is shared by a TMS9918-style CPU port and
// DMA_CHANNELS display-fetch read ports. The CPU side has a two-byte address
// setup FSM, a read-ahead latch (dout) and an auto-incrementing address. A
// CPU RAM operation waits in a one-deep pending slot. It runs in the first
// clock that no display fetch requests the RAM, so display fetches are never
// delayed by the CPU.
//
// Ports
//   clk, reset             pixel clock, asynchronous active-high reset
//   rd_tick, wr_tick       CPU strobes, one clk wide (wr_tick wins if both)
//   mode                   0 = data port, 1 = address/register port
//   din / dout             CPU write data / read-ahead latch
//   cpu_busy               CPU RAM op waiting in the pending slot
//   cpu_overrun            sticky: CPU data op issued while cpu_busy=1
//   reg_wr_tick, reg_num,  VDP register write decode (one-clk pulse)
//   reg_data
//   dma_addr, dma_rd_tick  per-channel fetch address / request
//   dma_dout, dma_valid    per-channel fetch data / one-clk update pulse
//
// Address FSM states
//   state     | meaning
//   ST_FIRST  | waiting for the address/register LSB byte
//   ST_SECOND | LSB latched, next mode=1 write is the MSB/command byte
module vram_mc #(
    parameter int VRAM_SIZE    = 16384,
    parameter int DMA_CHANNELS = 2,
    parameter int AW           = $clog2(VRAM_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_tick,
    input  logic                       wr_tick,
    input  logic                       mode,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       cpu_busy,
    output logic                       cpu_overrun,
    output logic                       reg_wr_tick,
    output logic [2:0]                 reg_num,
    output logic [7:0]                 reg_data,
    input  logic [DMA_CHANNELS*AW-1:0] dma_addr,
    input  logic [DMA_CHANNELS-1:0]    dma_rd_tick,
    output logic [DMA_CHANNELS*8-1:0]  dma_dout,
    output logic [DMA_CHANNELS-1:0]    dma_valid
);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } addr_state_e;

    addr_state_e state_q, state_d;
    logic [7:0]    lsb_q, lsb_d;
    logic [AW-1:0] addr_q, addr_d;

    // pending CPU slot
    logic          slot_valid_q, slot_valid_d;
    logic          slot_wr_q, slot_wr_d;
    logic [AW-1:0] slot_addr_q, slot_addr_d;
    logic [7:0]    slot_data_q, slot_data_d;

    logic          overrun_q, overrun_d;
    logic          reg_wr_tick_q, reg_wr_tick_d;
    logic [2:0]    reg_num_q, reg_num_d;
    logic [7:0]    reg_data_q, reg_data_d;
    logic [7:0]    dout_q, dout_d;

    // tags for the RAM read issued on the previous edge
    logic          rsp_cpu_q, rsp_cpu_d;
    logic          rsp_dma_q, rsp_dma_d;
    logic [1:0]    rsp_ch_q, rsp_ch_d;

    logic [DMA_CHANNELS-1:0][7:0] dma_dout_q, dma_dout_d;
    logic [DMA_CHANNELS-1:0]      dma_valid_q, dma_valid_d;

    // RAM access controls for this clock
    logic          dma_gnt;
    logic [1:0]    dma_gnt_idx;
    logic [AW-1:0] dma_gnt_addr;
    logic          cpu_exec;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] setup_addr;

    logic [7:0]    mem [VRAM_SIZE];
    logic [7:0]    ram_rdata_q;

    always_comb begin
        state_d       = state_q;
        lsb_d         = lsb_q;
        addr_d        = addr_q;
        slot_valid_d  = slot_valid_q;
        slot_wr_d     = slot_wr_q;
        slot_addr_d   = slot_addr_q;
        slot_data_d   = slot_data_q;
        overrun_d     = overrun_q;
        reg_wr_tick_d = 1'b0;
        reg_num_d     = reg_num_q;
        reg_data_d    = reg_data_q;
        dout_d        = dout_q;
        dma_dout_d    = dma_dout_q;
        dma_valid_d   = '0;

        // fixed priority: lowest-index requesting channel wins, the rest are dropped
        dma_gnt      = 1'b0;
        dma_gnt_idx  = 2'd0;
        dma_gnt_addr = '0;
        for (int i = DMA_CHANNELS - 1; i >= 0; i--) begin
            if (dma_rd_tick[i]) begin
                dma_gnt      = 1'b1;
                dma_gnt_idx  = 2'(i);
                dma_gnt_addr = dma_addr[i*AW +: AW];
            end
        end

        // the CPU only uses the RAM in a clock that no display fetch wants
        cpu_exec = slot_valid_q && !dma_gnt;
        ram_we   = cpu_exec && slot_wr_q;
        ram_re   = dma_gnt || (cpu_exec && !slot_wr_q);
        ram_addr = dma_gnt ? dma_gnt_addr : slot_addr_q;

        rsp_dma_d = dma_gnt;
        rsp_ch_d  = dma_gnt_idx;
        rsp_cpu_d = cpu_exec && !slot_wr_q;

        if (cpu_exec) begin
            slot_valid_d = 1'b0;
        end

        // deliver the read data issued on the previous edge
        if (rsp_dma_q) begin
            for (int i = 0; i < DMA_CHANNELS; i++) begin
                if (rsp_ch_q == 2'(i)) begin
                    dma_dout_d[i]  = ram_rdata_q;
                    dma_valid_d[i] = 1'b1;
                end
            end
        end
        if (rsp_cpu_q) begin
            dout_d = ram_rdata_q;
        end

        setup_addr = {din[AW-9:0], lsb_q};

        // CPU interface; a newly queued op overwrites the slot even when the
        // old op executes this same clock (the old one still runs from _q)
        if (wr_tick) begin
            if (mode) begin
                if (state_q == ST_FIRST) begin
                    lsb_d   = din;
                    state_d = ST_SECOND;
                end else begin
                    state_d = ST_FIRST;
                    case (din[7:6])
                        2'b00: begin
                            slot_valid_d = 1'b1;
                            slot_wr_d    = 1'b0;
                            slot_addr_d  = setup_addr;
                            addr_d       = setup_addr + AW'(1);
                        end
                        2'b01: begin
                            addr_d = setup_addr;
                        end
                        default: begin
                            reg_wr_tick_d = 1'b1;
                            reg_num_d     = din[2:0];
                            reg_data_d    = lsb_q;
                        end
                    endcase
                end
            end else begin
                slot_valid_d = 1'b1;
                slot_wr_d    = 1'b1;
                slot_addr_d  = addr_q;
                slot_data_d  = din;
                addr_d       = addr_q + AW'(1);
                dout_d       = din;
                if (slot_valid_q) begin
                    overrun_d = 1'b1;
                end
            end
        end else if (rd_tick) begin
            if (mode) begin
                // status read resynchronises the two-byte sequence
                state_d = ST_FIRST;
            end else begin
                slot_valid_d = 1'b1;
                slot_wr_d    = 1'b0;
                slot_addr_d  = addr_q;
                addr_d       = addr_q + AW'(1);
                if (slot_valid_q) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FIRST;
            lsb_q         <= '0;
            addr_q        <= '0;
            slot_valid_q  <= 1'b0;
            slot_wr_q     <= 1'b0;
            slot_addr_q   <= '0;
            slot_data_q   <= '0;
            overrun_q     <= 1'b0;
            reg_wr_tick_q <= 1'b0;
            reg_num_q     <= '0;
            reg_data_q    <= '0;
            dout_q        <= '0;
            rsp_cpu_q     <= 1'b0;
            rsp_dma_q     <= 1'b0;
            rsp_ch_q      <= '0;
            dma_dout_q    <= '0;
            dma_valid_q   <= '0;
        end else begin
            state_q       <= state_d;
            lsb_q         <= lsb_d;
            addr_q        <= addr_d;
            slot_valid_q  <= slot_valid_d;
            slot_wr_q     <= slot_wr_d;
            slot_addr_q   <= slot_addr_d;
            slot_data_q   <= slot_data_d;
            overrun_q     <= overrun_d;
            reg_wr_tick_q <= reg_wr_tick_d;
            reg_num_q     <= reg_num_d;
            reg_data_q    <= reg_data_d;
            dout_q        <= dout_d;
            rsp_cpu_q     <= rsp_cpu_d;
            rsp_dma_q     <= rsp_dma_d;
            rsp_ch_q      <= rsp_ch_d;
            dma_dout_q    <= dma_dout_d;
            dma_valid_q   <= dma_valid_d;
        end
    end

    // RAM array and its read register; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= slot_data_q;
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_addr];
        end
    end

    assign dout        = dout_q;
    assign cpu_busy    = slot_valid_q;
    assign cpu_overrun = overrun_q;
    assign reg_wr_tick = reg_wr_tick_q;
    assign reg_num     = reg_num_q;
    assign reg_data    = reg_data_q;
    assign dma_dout    = dma_dout_q;
    assign dma_valid   = dma_valid_q;

endmodule

// File: tb/tb_vram_mc.sv
module tb_vram_mc;

    localparam int AW = 14;
    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           rd_tick, wr_tick, mode;
    logic [7:0]     din;
    logic [7:0]     dout;
    logic           cpu_busy, cpu_overrun;
    logic           reg_wr_tick;
    logic [2:0]     reg_num;
    logic [7:0]     reg_data;
    logic [NCH*AW-1:0] dma_addr;
    logic [NCH-1:0]    dma_rd_tick;
    logic [NCH*8-1:0]  dma_dout;
    logic [NCH-1:0]    dma_valid;

    int n_cmp = 0;
    int n_err = 0;

    vram_mc #(.VRAM_SIZE(16384), .DMA_CHANNELS(NCH)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_tick     (rd_tick),
        .wr_tick     (wr_tick),
        .mode        (mode),
        .din         (din),
        .dout        (dout),
        .cpu_busy    (cpu_busy),
        .cpu_overrun (cpu_overrun),
        .reg_wr_tick (reg_wr_tick),
        .reg_num     (reg_num),
        .reg_data    (reg_data),
        .dma_addr    (dma_addr),
        .dma_rd_tick (dma_rd_tick),
        .dma_dout    (dma_dout),
        .dma_valid   (dma_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       exp_tick;
        logic [2:0] exp_num;
        logic [7:0] exp_data;
    } reg_vec_t;

    reg_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic m, input logic [7:0] d);
        mode = m; din = d; wr_tick = 1'b1;
        tick();
        wr_tick = 1'b0;
    endtask

    task automatic cpu_rd(input logic m);
        mode = m; rd_tick = 1'b1;
        tick();
        rd_tick = 1'b0;
    endtask

    // two-byte setup; waits until any read-ahead has reached dout
    task automatic set_addr(input logic [13:0] a, input logic wr);
        logic [7:0] msb;
        msb = {1'b0, wr, a[13:8]};
        cpu_wr(1'b1, a[7:0]);
        cpu_wr(1'b1, msb);
        tick();
        tick();
    endtask

    task automatic wr_data(input logic [7:0] d);
        cpu_wr(1'b0, d);
        tick();
    endtask

    task automatic dma_check(input int ch, input logic [13:0] a, input logic [7:0] exp, input string name);
        logic [NCH-1:0] exp_v;
        exp_v = '0;
        exp_v[ch] = 1'b1;
        dma_addr[ch*AW +: AW] = a;
        dma_rd_tick[ch] = 1'b1;
        tick();
        dma_rd_tick = '0;
        tick();
        check({name, "_valid"}, 32'(dma_valid), 32'(exp_v));
        check({name, "_data"}, 32'(dma_dout[ch*8 +: 8]), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{8'h12, 8'h80, 1'b1, 3'd0, 8'h12};
        vecs[1] = '{8'hFF, 8'hBD, 1'b1, 3'd5, 8'hFF};
        vecs[2] = '{8'h00, 8'h47, 1'b0, 3'd5, 8'hFF};
        vecs[3] = '{8'h34, 8'hC2, 1'b1, 3'd2, 8'h34};
        vecs[4] = '{8'h01, 8'h3F, 1'b0, 3'd2, 8'h34};
        vecs[5] = '{8'hA5, 8'hFE, 1'b1, 3'd6, 8'hA5};

        reset = 1'b1;
        rd_tick = 1'b0; wr_tick = 1'b0; mode = 1'b0; din = '0;
        dma_addr = '0; dma_rd_tick = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        check("rst_dout", 32'(dout), 32'h0);
        check("rst_busy", 32'(cpu_busy), 32'h0);
        check("rst_overrun", 32'(cpu_overrun), 32'h0);
        check("rst_reg_tick", 32'(reg_wr_tick), 32'h0);
        check("rst_reg_num", 32'(reg_num), 32'h0);
        check("rst_reg_data", 32'(reg_data), 32'h0);
        check("rst_dma_dout", 32'(dma_dout), 32'h0);
        check("rst_dma_valid", 32'(dma_valid), 32'h0);

        // register / address decode table
        for (int v = 0; v < 6; v++) begin
            cpu_wr(1'b1, vecs[v].lsb);
            cpu_wr(1'b1, vecs[v].msb);
            check($sformatf("vec%0d_tick", v), 32'(reg_wr_tick), 32'(vecs[v].exp_tick));
            check($sformatf("vec%0d_num", v), 32'(reg_num), 32'(vecs[v].exp_num));
            check($sformatf("vec%0d_data", v), 32'(reg_data), 32'(vecs[v].exp_data));
            tick();
            check($sformatf("vec%0d_pulse", v), 32'(reg_wr_tick), 32'h0);
            tick();
        end

        // fill 0x0000..0x00FF, then read back through the read-ahead latch
        set_addr(14'h0000, 1'b1);
        for (int i = 0; i < 256; i++) begin
            cpu_wr(1'b0, 8'(i));
            check($sformatf("fill_dout_%0d", i), 32'(dout), 32'(i));
            tick();
        end
        set_addr(14'h0000, 1'b0);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("readback_%0d", i), 32'(dout), 32'(i));
            cpu_rd(1'b0);
            tick();
            tick();
        end
        check("fill_overrun", 32'(cpu_overrun), 32'h0);

        // address wrap at the top of VRAM
        set_addr(14'h3FFF, 1'b1);
        wr_data(8'hA5);
        wr_data(8'h5C);
        set_addr(14'h3FFF, 1'b0);
        check("wrap_first", 32'(dout), 32'hA5);
        cpu_rd(1'b0);
        check("wrap_hold", 32'(dout), 32'hA5);
        tick();
        tick();
        check("wrap_second", 32'(dout), 32'h5C);

        // register write leaves the data address alone
        set_addr(14'h0010, 1'b0);
        check("reg_pre_dout", 32'(dout), 32'h10);
        cpu_wr(1'b1, 8'h5A);
        cpu_wr(1'b1, 8'h87);
        check("reg87_tick", 32'(reg_wr_tick), 32'h1);
        check("reg87_num", 32'(reg_num), 32'h7);
        check("reg87_data", 32'(reg_data), 32'h5A);
        cpu_rd(1'b0);
        tick();
        tick();
        check("reg_addr_kept", 32'(dout), 32'h11);

        // status read resets the byte sequence
        set_addr(14'h3311, 1'b1);
        wr_data(8'h6E);
        cpu_wr(1'b1, 8'h99);
        cpu_rd(1'b1);
        cpu_wr(1'b1, 8'h11);
        cpu_wr(1'b1, 8'h33);
        tick();
        tick();
        check("status_resync", 32'(dout), 32'h6E);

        // DMA arbitration with a CPU write pending
        set_addr(14'h1100, 1'b1);
        wr_data(8'hC3);
        set_addr(14'h1200, 1'b1);
        wr_data(8'hD4);
        set_addr(14'h2000, 1'b1);
        dma_addr = {14'h1200, 14'h1100};
        dma_rd_tick = 2'b11;
        mode = 1'b0; din = 8'h77; wr_tick = 1'b1;
        tick();
        wr_tick = 1'b0;
        check("arb_busy0", 32'(cpu_busy), 32'h1);
        check("arb_valid0", 32'(dma_valid), 32'h0);
        tick();
        check("arb_valid1", 32'(dma_valid), 32'h1);
        check("arb_ch0", 32'(dma_dout[7:0]), 32'hC3);
        check("arb_busy1", 32'(cpu_busy), 32'h1);
        dma_rd_tick = '0;
        tick();
        check("arb_busy2", 32'(cpu_busy), 32'h0);
        check("arb_valid2", 32'(dma_valid), 32'h1);
        tick();
        check("arb_valid3", 32'(dma_valid), 32'h0);
        check("arb_ch1_ungranted", 32'(dma_dout[15:8]), 32'h0);
        dma_check(1, 14'h2000, 8'h77, "cpu_write_landed");
        check("ch0_hold", 32'(dma_dout[7:0]), 32'hC3);
        dma_check(1, 14'h1200, 8'hD4, "ch1_1200");

        // overrun: two CPU writes while DMA owns every clock
        set_addr(14'h2100, 1'b1);
        wr_data(8'h01);
        wr_data(8'h02);
        set_addr(14'h2100, 1'b1);
        dma_addr[AW-1:0] = 14'h0000;
        dma_rd_tick = 2'b01;
        cpu_wr(1'b0, 8'hAA);
        check("ovr_first", 32'(cpu_overrun), 32'h0);
        cpu_wr(1'b0, 8'hBB);
        tick();
        check("ovr_set", 32'(cpu_overrun), 32'h1);
        check("ovr_busy", 32'(cpu_busy), 32'h1);
        dma_rd_tick = '0;
        tick();
        tick();
        check("ovr_busy_clr", 32'(cpu_busy), 32'h0);
        dma_check(1, 14'h2100, 8'h01, "ovr_first_dropped");
        dma_check(1, 14'h2101, 8'hBB, "ovr_second_landed");
        check("ovr_sticky", 32'(cpu_overrun), 32'h1);

        // asynchronous reset clears state but not RAM
        reset = 1'b1;
        #2;
        check("rst2_overrun", 32'(cpu_overrun), 32'h0);
        check("rst2_dout", 32'(dout), 32'h0);
        check("rst2_dma_dout", 32'(dma_dout), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        dma_check(0, 14'h2101, 8'hBB, "ram_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
